fclass_gen: RTL
===============

# fclass_gen

Class-directed single-precision value generator: the inverse of the FCLASS.S classifier. Given a one-hot 10-bit class mask in FCLASS bit order, it emits a burst of 32-bit IEEE-754 words that each belong to exactly that class, with pseudo-random payload from an internal LFSR. It feeds the FPU self-check path. Every emitted word, fed back through the classifier, must return the requested mask.

## Interface
Parameters:
- LFSR_SEED, 32'hACE1_2468: LFSR reset value. A value of 0 is replaced by 32'h1.

Ports (all on clk; active-low asynchronous reset):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high exactly when the FSM is in IDLE.
- req_class  in  10  class mask. Bit order:
  - 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0
  - 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN
- req_count  in  8  burst length; 0 means 256.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  32  generated float.
- out_last  out  1  marks the final word of the burst; qualified by out_valid.
- err  out  1  one-cycle pulse when a request mask is not one-hot.

## Operation
- **FSM states:** IDLE, EMIT.
- **IDLE behaviour:** req_ready=1. A request is accepted when req_valid & req_ready.
  - Mask not exactly one-hot (zero, or two or more bits set): err=1 for the next cycle. State stays IDLE. Nothing is latched.
  - Mask valid: latch the class into cls. Load rem = req_count, with 0 treated as 256 (9-bit counter). Load out_data = F(cls, lfsr). Set out_valid=1 and out_last=(rem==1). Go to EMIT.
- **EMIT behaviour:** req_ready=0. A transfer occurs when out_valid & out_ready.
  - On each transfer, lfsr advances one step.
  - rem==1: out_valid, out_last <= 0. Go to IDLE. out_data holds its last value.
  - Otherwise: rem <= rem-1, out_data <= F(cls, lfsr_next), out_last <= (rem==2).
  - No transfer (stall): out_data, out_last, rem and lfsr all hold.
- **LFSR step:** lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 0). The LFSR advances only on transfers, never in IDLE.
- **F(cls, r), fields {s, e[7:0], m[22:0]}:**
  - Sign: s=1 for bits 0-3; s=0 for bits 4-7; s=r[31] for NaNs.
  - ±inf: e=FF, m=0.
  - ±0: e=00, m=0.
  - ±subnormal: e=00, m=r[22:0]; if that is 0, m=23'h1.
  - ±normal: e=r[30:23], clamped so 00→01 and FF→FE; m=r[22:0].
  - sNaN: e=FF, m={1'b0, r[21:0]}; if r[21:0]==0, m=23'h1.
  - qNaN: e=FF, m={1'b1, r[21:0]}.
- **Reset:** asynchronous reset at any time, including mid-burst, aborts the burst. No out_last is issued.
- **Reset values:**
  - state=IDLE, req_ready=1, out_valid=0, out_last=0, err=0.
  - out_data=0, rem=0, cls=0, lfsr=LFSR_SEED.

## Timing
- **Latency:** a request accepted at edge N gives out_valid=1 from the cycle after N.
- **Throughput:** with out_ready held high, one word per cycle. A burst of K words completes at edge N+K.
- **Back-to-back bursts:** after the final transfer at edge M, req_ready=1 from the cycle after M. The earliest next accept is edge M+1, so there is one idle cycle between bursts.
- **Error pulse:** err is asserted in the cycle after the offending accept edge, for exactly one cycle.
- **Stall stability:** out_valid never drops without a transfer. out_data is stable while out_valid & !out_ready.
- **Ignored inputs:** req_valid is ignored while in EMIT. Changes to req_class or req_count after accept have no effect.

## Test plan
- **+inf:** from reset, req_class=10'h080, count=1 → out_data=32'h7F80_0000, out_last=1 on the first valid cycle, then req_ready=1.
- **+normal:** from reset, req_class=10'h040, count=1 → out_data=32'h2CE1_2468.
- **qNaN:** from reset, req_class=10'h200, count=1 → out_data=32'hFFE1_2468.
- **Invalid masks:** req_class=10'h003, then 10'h000 → err pulses once per request, out_valid stays 0, and the LFSR is unchanged (the next +normal request still gives 32'h2CE1_2468).
- **Long burst with stalls:** -0, count=3, with out_ready low for 5 cycles mid-burst → exactly three 32'h8000_0000 words, out_data stable during the stall, out_last only on the third. Then count=0 with -subnormal → exactly 256 transfers; every word has e=00, m≠0, s=1, and the classifier returns 10'h004 for each.
- **Reset mid-burst:** assert rst_n=0 mid-burst → out_valid drops immediately and req_ready=1. After release, a +normal count=1 request gives 32'h2CE1_2468.

Source files
------------

// File: rtl/fclass_gen.sv
// fclass_gen: class-directed single-precision value generator.
// Takes a one-hot FCLASS-ordered class mask and a burst length, then emits a
// stream of IEEE-754 single-precision words that each classify back to the
// requested class. The payload bits come from an internal 32-bit LFSR.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  high while idle (request can be accepted)
//   req_class  10-bit one-hot class mask, FCLASS bit order
//   req_count  burst length, 0 means 256
//   out_valid  out_data is valid
//   out_ready  consumer accepts out_data
//   out_data   generated float
//   out_last   final word of the burst (qualified by out_valid)
//   err        one-cycle pulse after a non-one-hot request mask
//
// States:
//   IDLE | waiting for a request, req_ready=1
//   EMIT | streaming words, out_valid=1
module fclass_gen #(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_class,
  input  logic [7:0]  req_count,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        err
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state;
  state_t      state_next;
  logic [9:0]  cls;
  logic [8:0]  rem;
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic        mask_ok;
  logic        accept;
  logic        xfer;

  // Builds a word of class c from random bits r. Fields left at zero cover
  // the +/-0 classes.
  function automatic logic [31:0] gen_word(input logic [9:0] c, input logic [31:0] r);
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    s = (|c[3:0]) | ((c[8] | c[9]) & r[31]);
    e = 8'h00;
    m = 23'h0;
    if (c[0] | c[7]) begin
      e = 8'hFF;
    end else if (c[2] | c[5]) begin
      m = (r[22:0] == 23'h0) ? 23'h1 : r[22:0];
    end else if (c[1] | c[6]) begin
      e = r[30:23];
      if (e == 8'h00)      e = 8'h01;
      else if (e == 8'hFF) e = 8'hFE;
      m = r[22:0];
    end else if (c[8]) begin
      e = 8'hFF;
      m = (r[21:0] == 22'h0) ? 23'h1 : {1'b0, r[21:0]};
    end else if (c[9]) begin
      e = 8'hFF;
      m = {1'b1, r[21:0]};
    end
    return {s, e, m};
  endfunction

  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign mask_ok   = (req_class != 10'h0) && ((req_class & (req_class - 10'h1)) == 10'h0);
  assign accept    = req_valid & req_ready;
  assign xfer      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && mask_ok) state_next = EMIT;
      EMIT:    if (xfer && rem == 9'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    out_valid = (state == EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls      <= 10'h0;
      rem      <= 9'h0;
      lfsr     <= SEED;
      out_data <= 32'h0;
      out_last <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= accept & ~mask_ok;
      if (accept && mask_ok) begin
        cls      <= req_class;
        rem      <= {req_count == 8'd0, req_count};
        out_data <= gen_word(req_class, lfsr);
        out_last <= (req_count == 8'd1);
      end else if (xfer) begin
        lfsr <= lfsr_next;
        if (rem == 9'd1) begin
          // out_data keeps the final word after the burst ends.
          out_last <= 1'b0;
        end else begin
          rem      <= rem - 9'd1;
          out_data <= gen_word(cls, lfsr_next);
          out_last <= (rem == 9'd2);
        end
      end
    end
  end

endmodule
